// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and parameter defaults for the memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, ACK} state_e;
    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int MAX_STREAK_DEF = 3;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data accesses,
// favouring data but granting fetch after MAX_STREAK consecutive data wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_STREAK = MAX_STREAK_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);
    localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              we_q, we_d, dwin_q, dwin_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              pick_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        dwin_d   = dwin_q;
        streak_d = streak_q;
        pick_d   = d_req && (streak_q < SW'(MAX_STREAK) || !if_req);
        case (state_q)
            IDLE: begin
                // Streak only counts data wins that made a waiting fetch wait longer.
                streak_d = !if_req ? '0 :
                           !pick_d ? '0 :
                           (streak_q == SW'(MAX_STREAK)) ? streak_q : streak_q + SW'(1);
                if (d_req || if_req) begin
                    state_d = pick_d ? GNT_D : GNT_IF;
                    dwin_d  = pick_d;
                    addr_d  = pick_d ? d_addr : if_addr;
                    we_d    = pick_d && d_we;
                    wdata_d = pick_d ? d_wdata : '0;
                end
            end
            GNT_IF, GNT_D: begin
                state_d = mem_ready ? ACK : state_q;
                rdata_d = (mem_ready && !we_q) ? mem_rdata : rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            dwin_q   <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            dwin_q   <= dwin_d;
            streak_q <= streak_d;
        end
    end

    assign mem_en    = (state_q == GNT_IF) || (state_q == GNT_D);
    assign mem_we    = (state_q == GNT_D) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign busy      = state_q != IDLE;
    assign if_ack    = (state_q == ACK) && !dwin_q;
    assign d_ack     = (state_q == ACK) && dwin_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for arbitration fairness and reset abort.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic        if_ack, d_ack, mem_en, mem_we, busy;
    logic [31:0] rdata, mem_addr, mem_wdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifr;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        rdy;
        logic [31:0] mrd;
        logic        en;
        logic        we;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic        ifa;
        logic        dack;
        logic [31:0] rd;
        logic        bsy;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else pass_cnt++;
    endtask

    initial begin
        vec_t  v [13];
        string seq;
        int    n;
        logic  both;

        v[0]  = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0,                        0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0};
        v[1]  = '{1, 32'h0040_0000, 0, 0, 32'h0, 32'h0, 1, 32'h2008_0005,        1, 0, 32'h0040_0000, 32'h0,       0, 0, 32'h0,        1};
        v[2]  = '{1, 32'h0040_0000, 0, 0, 32'h0, 32'h0, 1, 32'h2008_0005,        0, 0, 32'h0040_0000, 32'h0,       1, 0, 32'h2008_0005, 1};
        v[3]  = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0,                        0, 0, 32'h0040_0000, 32'h0,       0, 0, 32'h2008_0005, 0};
        v[4]  = '{0, 32'h0, 1, 1, 32'h1000_0010, 32'hDEAD_BEEF, 0, 32'h1111_1111, 1, 1, 32'h1000_0010, 32'hDEAD_BEEF, 0, 0, 32'h2008_0005, 1};
        v[5]  = v[4];
        v[6]  = v[4];
        v[7]  = v[4];
        v[8]  = '{0, 32'h0, 1, 1, 32'h1000_0010, 32'hDEAD_BEEF, 1, 32'h1111_1111, 0, 0, 32'h1000_0010, 32'hDEAD_BEEF, 0, 1, 32'h2008_0005, 1};
        v[9]  = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0,                        0, 0, 32'h1000_0010, 32'hDEAD_BEEF, 0, 0, 32'h2008_0005, 0};
        v[10] = '{0, 32'h0, 1, 0, 32'h1000_0020, 32'h0, 1, 32'hCAFE_0001,        1, 0, 32'h1000_0020, 32'h0,       0, 0, 32'h2008_0005, 1};
        v[11] = '{0, 32'h0, 1, 0, 32'h1000_0020, 32'h0, 1, 32'hCAFE_0001,        0, 0, 32'h1000_0020, 32'h0,       0, 1, 32'hCAFE_0001, 1};
        v[12] = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0,                        0, 0, 32'h1000_0020, 32'h0,       0, 0, 32'hCAFE_0001, 0};

        #12;
        chk("reset_outputs", {24'h0, mem_en, mem_we, if_ack, d_ack, busy, 3'b0}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_addr", mem_addr, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            if_req = v[i].ifr; if_addr = v[i].ia; d_req = v[i].dr; d_we = v[i].dw;
            d_addr = v[i].da; d_wdata = v[i].dwd; mem_ready = v[i].rdy; mem_rdata = v[i].mrd;
            @(posedge clk); #1;
            chk($sformatf("v%0d_mem_en", i), {31'h0, mem_en}, {31'h0, v[i].en});
            chk($sformatf("v%0d_mem_we", i), {31'h0, mem_we}, {31'h0, v[i].we});
            chk($sformatf("v%0d_mem_addr", i), mem_addr, v[i].ma);
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v[i].mwd);
            chk($sformatf("v%0d_if_ack", i), {31'h0, if_ack}, {31'h0, v[i].ifa});
            chk($sformatf("v%0d_d_ack", i), {31'h0, d_ack}, {31'h0, v[i].dack});
            chk($sformatf("v%0d_rdata", i), rdata, v[i].rd);
            chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, v[i].bsy});
        end

        // Fetch address changes while the grant is waiting on memory.
        if_req = 1'b1; if_addr = 32'h0040_0000; mem_ready = 1'b0; mem_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        chk("addr_hold_grant", {31'h0, mem_en}, 32'h1);
        if_addr = 32'h0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("addr_hold_addr", mem_addr, 32'h0040_0000);
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("addr_hold_ack", {31'h0, if_ack}, 32'h1);
        chk("addr_hold_rdata", rdata, 32'h0BAD_F00D);
        if_req = 1'b0; mem_ready = 1'b0;

        repeat (10) begin
            @(posedge clk); #1;
            chk("idle_bus", {28'h0, mem_en, busy, if_ack, d_ack}, 32'h0);
        end

        // Both requesters held: data wins three times, then fetch.
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h100; d_addr = 32'h200; mem_ready = 1'b1;
        seq = ""; n = 0; both = 1'b0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(posedge clk); #1;
            if (if_ack && d_ack) both = 1'b1;
            if (d_ack) begin seq = {seq, "D"}; n++; end
            if (if_ack) begin seq = {seq, "I"}; n++; end
        end
        total_cnt++;
        if (seq != "DDDIDDDI") $display("FAIL grant_order: got '%s' expected 'DDDIDDDI'", seq);
        else pass_cnt++;
        chk("ack_exclusive", {31'h0, both}, 32'h0);
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a waiting store grant.
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0030; d_wdata = 32'h55; mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("abort_pre_en", {31'h0, mem_en}, 32'h1);
        chk("abort_pre_we", {31'h0, mem_we}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", {27'h0, mem_en, mem_we, busy, d_ack, if_ack}, 32'h0);
        chk("abort_streak", {30'h0, dut.streak_q}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        chk("abort_hold", {29'h0, mem_en, d_ack, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_arb_en", {31'h0, mem_en}, 32'h1);
        chk("first_arb_addr", mem_addr, 32'h1000_0030);
        if_req = 1'b0; d_req = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
